msrv32_fetch_unit: RTL

Instruction fetch stage of the msrv32 core. Generates the fetch PC, issues requests to instruction memory over a valid/ready bus, and buffers returned words in a 2-entry instruction+PC queue. Drives the instruction mux: supplies the raw instruction word, its PC, and `flush_out`. When `flush_out` is high, the mux substitutes a NOP.

---
 rtl/msrv32_pkg.sv | 19 +
 rtl/msrv32_fetch_fifo.sv | 58 +++++
 rtl/msrv32_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 fetch stage.
package msrv32_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned FETCH_DEPTH = 2;

    localparam logic [XLEN-1:0] MSRV32_NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] MSRV32_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Two-entry instruction+PC queue between the fetch bus and the instruction mux.
module msrv32_fetch_fifo
    import msrv32_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entry_q [FETCH_DEPTH];
    fetch_entry_t entry_d [FETCH_DEPTH];
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_pop;
    logic         do_push;
    logic         wr_idx;

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        // Slot that becomes the tail after an optional pop: count - pop, only ever 0 or 1.
        wr_idx  = count_q[0] ^ do_pop;
        if (clear) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                entry_d[0] = entry_q[1];
            end
            if (do_push) begin
                entry_d[wr_idx] = push_data;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
            for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    assign count = count_q;
    assign head  = entry_q[0];

endmodule

// File: rtl/msrv32_fetch_unit.sv
// msrv32 instruction fetch: PC generation, valid/ready fetch bus, 2-deep queue feeding the mux.
// Optional MSRV32_FETCH_MISALIGN_EN adds instr_addr_misaligned_out on misaligned redirects.
module msrv32_fetch_unit
    import msrv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = MSRV32_RESET_PC
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    input  logic            stall_in,
    output logic [XLEN-1:0] imaddr_out,
    output logic            imreq_out,
    input  logic            ms_riscv32_mp_instr_hready_in,
    input  logic            ms_riscv32_mp_instr_rvalid_in,
    input  logic [XLEN-1:0] ms_riscv32_mp_instr_in,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
`ifdef MSRV32_FETCH_MISALIGN_EN
    output logic            instr_addr_misaligned_out,
`endif
    output logic            flush_out
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] req_pc_d;
    logic            outstanding_q;
    logic            outstanding_d;
    logic            drop_q;
    logic            drop_d;

    logic [1:0]      fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_push_data;
    logic            empty;
    logic            pop;
    logic            push;
    logic            accept;
    logic            resp;
    logic [2:0]      occupancy;
    logic            issue_ok;

    always_comb begin
        empty     = (fifo_count == 2'd0);
        pop       = !empty && !stall_in;
        occupancy = {1'b0, fifo_count} + {2'b00, outstanding_q};
        issue_ok  = (occupancy - {2'b00, pop}) < 3'd2;
        imreq_out = ms_riscv32_mp_rst_in && !branch_taken_in && issue_ok;
        accept    = imreq_out && ms_riscv32_mp_instr_hready_in;
        resp      = ms_riscv32_mp_instr_rvalid_in && outstanding_q;
        push      = resp && !drop_q && !branch_taken_in;
    end

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (accept) begin
            pc_d          = pc_q + 32'd4;
            req_pc_d      = pc_q;
            outstanding_d = 1'b1;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end
        if (resp) begin
            drop_d = 1'b0;
        end
        // A response landing in the redirect cycle is already blocked from the queue, so
        // only a request still owed after this edge needs to be discarded later.
        if (branch_taken_in) begin
            pc_d   = word_align(redirect_pc_in);
            drop_d = outstanding_d;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    always_comb begin
        fifo_push_data       = '0;
        fifo_push_data.instr = ms_riscv32_mp_instr_in;
        fifo_push_data.pc    = req_pc_q;
    end

    msrv32_fetch_fifo u_fifo (
        .clk_in    (ms_riscv32_mp_clk_in),
        .rst_n_in  (ms_riscv32_mp_rst_in),
        .push      (push),
        .push_data (fifo_push_data),
        .pop       (pop),
        .clear     (branch_taken_in),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        imaddr_out = pc_q;
        flush_out  = empty;
        instr_out  = empty ? MSRV32_NOP : fifo_head.instr;
        pc_out     = empty ? pc_q : fifo_head.pc;
    end

`ifdef MSRV32_FETCH_MISALIGN_EN
    logic misalign_q;
    logic misalign_d;

    always_comb begin
        misalign_d = branch_taken_in && (redirect_pc_in[1:0] != 2'b00);
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign instr_addr_misaligned_out = misalign_q;
`endif

endmodule
